// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the multi-pattern serial
// sequence detector.
//   fill_state_e : history fill FSM states (FILL, ARMED)
//   idx_w()      : width of a lane-select field for n lanes (never below 1)
//   PAT_0110 / PAT_1001 : default 4-bit reset patterns
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_e;

    localparam logic [3:0] PAT_0110 = 4'b0110;
    localparam logic [3:0] PAT_1001 = 4'b1001;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_det_multi_if.sv
// seq_det_multi_if: stream, configuration and status bundle of the
// multi-pattern sequence detector.
//   master : serial source / configuration side (drives stream and cfg)
//   slave  : detector side (drives hit, any_hit, hit_cnt, primed)
// Optional macro SEQ_DET_MASK_EN adds cfg_mask (per-lane don't-care mask).
interface seq_det_multi_if
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = idx_w(NUM_PAT);

    logic                     bit_valid;
    logic                     bit_in;
    logic                     overlap;
    logic                     cfg_we;
    logic [IDX_W-1:0]         cfg_idx;
    logic [PAT_LEN-1:0]       cfg_pattern;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0]       cfg_mask;
`endif
    logic                     clear_cnt;
    logic [NUM_PAT-1:0]       hit;
    logic                     any_hit;
    logic [NUM_PAT*CNT_W-1:0] hit_cnt;
    logic                     primed;

    modport master (
`ifdef SEQ_DET_MASK_EN
        output cfg_mask,
`endif
        output bit_valid, bit_in, overlap, cfg_we, cfg_idx, cfg_pattern, clear_cnt,
        input  hit, any_hit, hit_cnt, primed
    );

    modport slave (
`ifdef SEQ_DET_MASK_EN
        input  cfg_mask,
`endif
        input  bit_valid, bit_in, overlap, cfg_we, cfg_idx, cfg_pattern, clear_cnt,
        output hit, any_hit, hit_cnt, primed
    );

endinterface

// File: rtl/seq_match_lane.sv
// seq_match_lane: one pattern lane of the sequence detector.
// Holds the lane pattern (and mask when SEQ_DET_MASK_EN is defined),
// compares it against the post-shift window, registers the hit pulse and
// keeps a saturating hit counter.
//   window      : history window including the bit being accepted
//   fire        : a bit is accepted and the window is fully primed
//   cfg_we      : load cfg_pattern (and cfg_mask) into this lane
//   clear_cnt   : synchronous counter clear, wins over an increment
//   match       : combinational compare result
//   hit/hit_cnt : registered hit pulse and counter
module seq_match_lane #(
    parameter int                 PAT_LEN  = 4,
    parameter int                 CNT_W    = 8,
    parameter logic [PAT_LEN-1:0] INIT_PAT = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PAT_LEN-1:0] window,
    input  logic               fire,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_LEN-1:0] cfg_mask,
`endif
    input  logic               clear_cnt,
    output logic               match,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt
);

    logic [PAT_LEN-1:0] pattern;
`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0] mask;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
`ifdef SEQ_DET_MASK_EN
        match = (((window ^ pattern) & mask) == '0);
`else
        match = (window == pattern);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= INIT_PAT;
`ifdef SEQ_DET_MASK_EN
            mask    <= '1;
`endif
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            hit <= fire && match;
            if (cfg_we) begin
                pattern <= cfg_pattern;
`ifdef SEQ_DET_MASK_EN
                mask    <= cfg_mask;
`endif
            end
            // The counter steps on the same edge that registers the hit.
            if (clear_cnt)
                hit_cnt <= '0;
            else if (fire && match)
                hit_cnt <= sat_inc(hit_cnt);
        end
    end

endmodule

// File: rtl/seq_det_multi.sv
// seq_det_multi: serial bit-stream detector with NUM_PAT runtime-loadable
// patterns of PAT_LEN bits (first received bit = pattern MSB), selectable
// overlapping / non-overlapping matching and a saturating hit counter per lane.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : seq_det_multi_if.slave
//                in : bit_valid, bit_in, overlap, cfg_we, cfg_idx,
//                     cfg_pattern, clear_cnt (cfg_mask with SEQ_DET_MASK_EN)
//                out: hit, any_hit, hit_cnt (lane i at [i*CNT_W +: CNT_W]), primed
// Optional macro SEQ_DET_MASK_EN: per-lane don't-care mask (mask bit 0 = ignore).
module seq_det_multi
    import seq_det_pkg::*;
#(
    parameter int                         PAT_LEN       = 4,
    parameter int                         NUM_PAT       = 2,
    parameter int                         CNT_W         = 8,
    parameter logic [NUM_PAT*PAT_LEN-1:0] INIT_PATTERNS = {PAT_1001, PAT_0110}
) (
    input logic            clk,
    input logic            reset,
    seq_det_multi_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_PAT);
    localparam int FCW   = $clog2(PAT_LEN + 1);

    fill_state_e              state;
    logic [FCW-1:0]           fill_cnt;
    logic [PAT_LEN-1:0]       history;
    logic [PAT_LEN-1:0]       window;
    logic                     primed_r;
    logic                     any_hit_r;
    logic [IDX_W:0]           idx_ext;
    logic                     cfg_ok;
    logic                     fire;
    logic                     completes_fill;
    logic                     lane_fire;
    logic                     flush_hit;
    logic [NUM_PAT-1:0]       match;
    logic [NUM_PAT-1:0]       hit_v;
    logic [NUM_PAT*CNT_W-1:0] cnt_v;

    always_comb begin
        idx_ext        = {1'b0, bus.cfg_idx};
        // Out-of-range lane selects neither write nor flush.
        cfg_ok         = bus.cfg_we && (idx_ext < (IDX_W+1)'(NUM_PAT));
        // A config write swallows a coincident bit.
        fire           = bus.bit_valid && !cfg_ok;
        window         = (history << 1) | PAT_LEN'(bus.bit_in);
        completes_fill = (state == FILL) && (fill_cnt == FCW'(PAT_LEN - 1));
        lane_fire      = fire && ((state == ARMED) || completes_fill);
        flush_hit      = lane_fire && (|match) && !bus.overlap;
    end

    // Fill FSM, history register and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            history   <= '0;
            primed_r  <= 1'b0;
            any_hit_r <= 1'b0;
        end else begin
            any_hit_r <= lane_fire && (|match);
            if (cfg_ok) begin
                state    <= FILL;
                fill_cnt <= '0;
                history  <= '0;
                primed_r <= 1'b0;
            end else if (fire) begin
                history <= window;
                if (flush_hit) begin
                    // Non-overlapping mode: the next PAT_LEN bits must all be new.
                    state    <= FILL;
                    fill_cnt <= '0;
                    primed_r <= 1'b0;
                end else if (state == FILL) begin
                    if (completes_fill) begin
                        state    <= ARMED;
                        fill_cnt <= FCW'(PAT_LEN);
                        primed_r <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + FCW'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
        seq_match_lane #(
            .PAT_LEN  (PAT_LEN),
            .CNT_W    (CNT_W),
            .INIT_PAT (INIT_PATTERNS[i*PAT_LEN +: PAT_LEN])
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .window      (window),
            .fire        (lane_fire),
            .cfg_we      (cfg_ok && (bus.cfg_idx == IDX_W'(i))),
            .cfg_pattern (bus.cfg_pattern),
`ifdef SEQ_DET_MASK_EN
            .cfg_mask    (bus.cfg_mask),
`endif
            .clear_cnt   (bus.clear_cnt),
            .match       (match[i]),
            .hit         (hit_v[i]),
            .hit_cnt     (cnt_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.hit     = hit_v;
    assign bus.any_hit = any_hit_r;
    assign bus.hit_cnt = cnt_v;
    assign bus.primed  = primed_r;

endmodule

// File: doc/seq_det_multi.md
Name: seq_det_multi

Overview:
- Parametrised successor to the fixed dual 4-bit Moore detector.
- Watches a serial bit stream and reports hits against NUM_PAT runtime-loadable patterns of PAT_LEN bits each.
- Selectable overlapping or non-overlapping matching; one saturating hit counter per pattern.
- Sits between the sequence generator (or any serial source, qualified by bit_valid) and the LED/status logic, in the divided-clock domain.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16); first-received bit is pattern MSB
NUM_PAT, 2, number of independent pattern lanes (1..8)
CNT_W, 8, width of each hit counter
INIT_PATTERNS, {4'b1001,4'b0110}, NUM_PAT*PAT_LEN reset patterns; lane i = slice [i*PAT_LEN +: PAT_LEN]

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
bit_valid  in  1  bit_in is sampled this cycle
bit_in  in  1  serial data bit
overlap  in  1  1 = overlapping matches, 0 = flush history after any hit
cfg_we  in  1  write cfg_pattern into lane cfg_idx
cfg_idx  in  $clog2(NUM_PAT) (min 1)  lane select
cfg_pattern  in  PAT_LEN  new pattern value
clear_cnt  in  1  synchronous clear of all hit counters
hit  out  NUM_PAT  one-cycle registered hit pulse per lane
any_hit  out  1  OR of hit, registered together with it
hit_cnt  out  NUM_PAT*CNT_W  flattened counters; lane i at [i*CNT_W +: CNT_W]
primed  out  1  history window holds PAT_LEN valid bits

Behaviour:
- Reset values: history = 0, fill count = 0, hit = 0, any_hit = 0, hit_cnt = 0, primed = 0, patterns = INIT_PATTERNS.
- History: PAT_LEN shift register, shift-left with bit_in entering the LSB on bit_valid.
- Fill control FSM, two states:
  - FILL: count accepted bits. On reaching PAT_LEN, go to ARMED.
  - ARMED: primed = 1.
- Compare rule: on a bit_valid edge, lane i hits when the post-shift window equals pattern i AND (state is ARMED, or this bit completes the fill).
- Latency: hit[i] goes high in the cycle after the edge that sampled the completing bit, for exactly one cycle. Consecutive matches give consecutive pulses.
- No bit_valid: history, fill count and FSM hold; hit = 0.
- Non-overlap (overlap = 0): any lane hit sends fill count to 0 and the FSM to FILL. The next PAT_LEN bits must all be new.
- Overlap (overlap = 1): history is never flushed on a hit.
- Several lanes hitting on the same bit is legal; all corresponding hit bits assert.
- cfg_we:
  - Writes the pattern and flushes history (FSM to FILL, fill count to 0), so no stale-window hit.
  - Has priority over bit_valid in the same cycle; that bit is discarded.
  - cfg_idx >= NUM_PAT: write ignored, no flush.
- hit_cnt[i]: +1 per hit[i] pulse (counted at the edge that registers the hit); saturates at 2^CNT_W-1.
- clear_cnt: wins over a simultaneous increment (result 0). Does not affect history or patterns.
- Changing overlap mid-stream takes effect on the next accepted bit.
- reset mid-stream: everything returns to reset values immediately and asynchronously, including patterns.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- When defined:
  - Adds input cfg_mask (PAT_LEN) and a per-lane mask register, reset all ones, written with cfg_pattern under cfg_we.
  - Match becomes ((window ^ pattern) & mask) == 0; mask bit 0 = don't-care.
- When undefined: no cfg_mask port or mask storage; exact match only.

Decomposition:
- Package seq_det_pkg:
  - Fill FSM enum {FILL, ARMED}.
  - Helper constant function for index width (min 1).
  - Default pattern constants PAT_0110 / PAT_1001.
- Sub-module seq_match_lane, instantiated NUM_PAT times in a generate loop:
  - Holds pattern (and mask), comparator, hit register and saturating counter.
  - Inputs: window, fire strobe, cfg write strobe, clear_cnt.
- Top keeps the history, fill FSM, flush logic and output packing.

Test Plan:
- Defaults, overlap = 0, stream 1001_0110_1100_0011 (one bit per cycle, MSB first) -> hit[1] after bit 4, hit[0] after bit 8, nothing else. Final hit_cnt lane0 = 1, lane1 = 1.
- Same stream, overlap = 1 -> hit[1] after bit 4, hit[0] after bits 8 and 11. Final lane0 = 2, lane1 = 1.
- Stream 0110 with bit_valid gaps of 3 idle cycles between bits -> single hit[0] one cycle after the 4th valid bit; primed stays 0 until then.
- cfg_we lane0 = 4'b1111 asserted with bit_valid = 1 mid-stream, then stream 1111 -> the concurrent bit is discarded, primed drops to 0, hit[0] after the 4th new bit.
- CNT_W = 2, overlap = 1, stream of 0110 repeated 5 times -> lane0 saturates at 3. clear_cnt coincident with a hit -> counter reads 0.
- Assert reset while primed = 1 and a hit is pending -> hit, primed and counters go to 0 without a clock edge, and patterns return to 0110/1001.
